sysctrl_host: RTL and testbench

Initiator for the sysctrl byte-stream command bus. It accepts command requests from on-chip logic, serializes each as a command byte plus 0–4 payload bytes with `start`/`strobe` framing, and captures the slave's response bytes. When enabled, it also services the slave's interrupt line on its own with a status-read / acknowledge sequence of two CMD 5 transactions. It replaces the external MCU as bus master in MCU-less builds and in the self-test bench.

---
 rtl/sysctrl_pkg.sv | 48 ++++
 rtl/sysctrl_host.sv | 180 ++++++++++++++++++
 tb/tb_sysctrl_host.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg: definitions shared by the sysctrl bus initiator and its
// users: command codes, the status magic bytes, the host FSM state and
// transaction-source enums, and two small helpers.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_LEDS    = 8'd1;
  localparam logic [7:0] CMD_COLOR   = 8'd2;
  localparam logic [7:0] CMD_BUTTONS = 8'd3;
  localparam logic [7:0] CMD_CONFIG  = 8'd4;
  localparam logic [7:0] CMD_IRQ     = 8'd5;

  // Bytes returned by CMD_STATUS, in order.
  localparam logic [7:0] STATUS_MAGIC0 = 8'h5C;
  localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_USER,
    SRC_IRQ_RD,
    SRC_IRQ_ACK
  } src_t;

  // Payload lengths above 4 are treated as 4.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'd4) ? 3'd4 : len;
  endfunction

  // Byte i (0..3) of a 32-bit word, LSB byte first.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sysctrl_host.sv
// sysctrl_host: initiator for the sysctrl byte-stream command bus.
// Serializes a command byte plus 0..4 payload bytes with start/strobe
// framing, captures one response byte after each payload strobe, and
// optionally services the slave interrupt with a CMD_IRQ read followed by
// a CMD_IRQ acknowledge of the status it read.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_*               user request (cmd, len 0..4, payload LSB byte first)
//   rsp_valid/rsp_data  one-cycle completion pulse, response held until next
//   auto_irq, int_in_n  interrupt service enable, active-low slave interrupt
//   irq_valid/irq_status one-cycle pulse with the status read from the slave
//   busy                state is not IDLE
//   bus_strobe/start/dout, bus_din  byte bus to/from the slave
//   fsm_state           current FSM state, for observation
//
// Handshake: a request transfers on a cycle where req_valid && req_ready.
// req_ready is high only in IDLE when no interrupt service is starting in
// the same cycle; req_* are ignored in every other cycle.
module sysctrl_host
  import sysctrl_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        auto_irq,
  input  logic        int_in_n,
  output logic        irq_valid,
  output logic [7:0]  irq_status,
  output logic        busy,
  output logic        bus_strobe,
  output logic        bus_start,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output state_t      fsm_state
);

  // WAIT lasts GAP-1 cycles; the counter is preloaded with GAP-2.
  localparam logic [3:0] WAIT_INIT = (GAP > 1) ? 4'(GAP - 2) : 4'd0;

  state_t      state;
  src_t        src;
  logic [2:0]  idx;
  logic [2:0]  len;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic [31:0] rx_buf;
  logic [31:0] rx_next;
  logic [3:0]  wait_cnt;
  logic        irq_start;

  assign irq_start = auto_irq && !int_in_n;
  assign req_ready = (state == ST_IDLE) && !irq_start;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  // Response buffer with the byte sampled this cycle merged in. Byte k of
  // the response follows payload strobe k+1, hence the index-1 offset.
  always_comb begin
    rx_next = rx_buf;
    case (idx)
      3'd1:    rx_next[7:0]   = bus_din;
      3'd2:    rx_next[15:8]  = bus_din;
      3'd3:    rx_next[23:16] = bus_din;
      3'd4:    rx_next[31:24] = bus_din;
      default: rx_next = rx_buf;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      src        <= SRC_USER;
      idx        <= 3'd0;
      len        <= 3'd0;
      cmd        <= 8'd0;
      data       <= 32'd0;
      rx_buf     <= 32'd0;
      wait_cnt   <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      irq_valid  <= 1'b0;
      irq_status <= 8'd0;
      bus_strobe <= 1'b0;
      bus_start  <= 1'b0;
      bus_dout   <= 8'd0;
    end else begin
      bus_strobe <= 1'b0;
      bus_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      irq_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Interrupt service wins a tie; the user request stays pending.
          if (irq_start) begin
            src        <= SRC_IRQ_RD;
            cmd        <= CMD_IRQ;
            len        <= 3'd1;
            data       <= 32'd0;
            idx        <= 3'd0;
            rx_buf     <= 32'd0;
            state      <= ST_SEND;
            bus_strobe <= 1'b1;
            bus_start  <= 1'b1;
            bus_dout   <= CMD_IRQ;
          end else if (req_valid) begin
            src        <= SRC_USER;
            cmd        <= req_cmd;
            len        <= clamp_len(req_len);
            data       <= req_data;
            idx        <= 3'd0;
            rx_buf     <= 32'd0;
            state      <= ST_SEND;
            bus_strobe <= 1'b1;
            bus_start  <= 1'b1;
            bus_dout   <= req_cmd;
          end
        end
        ST_SEND: begin
          if (GAP > 1) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end else begin
            state <= ST_SAMPLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_SAMPLE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_SAMPLE: begin
          rx_buf <= rx_next;
          if (idx < len) begin
            idx        <= idx + 3'd1;
            state      <= ST_SEND;
            bus_strobe <= 1'b1;
            bus_dout   <= byte_of(data, idx[1:0]);
          end else begin
            state <= ST_DONE;
            if (src == SRC_USER) begin
              rsp_valid <= 1'b1;
              rsp_data  <= rx_next;
            end else if (src == SRC_IRQ_RD) begin
              irq_valid  <= 1'b1;
              irq_status <= rx_next[7:0];
            end
          end
        end
        ST_DONE: begin
          // A non-zero status is acknowledged straight away, without
          // returning to IDLE, so no user request can slip in between.
          if (src == SRC_IRQ_RD && irq_status != 8'd0) begin
            src        <= SRC_IRQ_ACK;
            cmd        <= CMD_IRQ;
            len        <= 3'd1;
            data       <= {24'd0, irq_status};
            idx        <= 3'd0;
            rx_buf     <= 32'd0;
            state      <= ST_SEND;
            bus_strobe <= 1'b1;
            bus_start  <= 1'b1;
            bus_dout   <= CMD_IRQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysctrl_host.sv
// tb_sysctrl_host: self-checking bench for sysctrl_host with GAP = 2 and a
// small behavioural sysctrl slave (status magic, bit-reversed colour,
// config echo, interrupt status/acknowledge).
module tb_sysctrl_host;
  import sysctrl_pkg::*;

  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd;
  logic [2:0]  req_len;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        auto_irq, int_in_n;
  logic        irq_valid;
  logic [7:0]  irq_status;
  logic        busy, bus_strobe, bus_start;
  logic [7:0]  bus_dout, bus_din;
  state_t      fsm_state;

  sysctrl_host #(.GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .auto_irq(auto_irq), .int_in_n(int_in_n),
    .irq_valid(irq_valid), .irq_status(irq_status),
    .busy(busy), .bus_strobe(bus_strobe), .bus_start(bus_start),
    .bus_dout(bus_dout), .bus_din(bus_din),
    .fsm_state(fsm_state)
  );

  // ---------------- slave model + monitors ----------------
  logic [7:0]  s_cmd = 8'h00;
  logic [7:0]  s_dout = 8'h00;
  logic [7:0]  s_int = 8'h00;
  logic [2:0]  s_cnt = 3'd0;
  logic [23:0] s_color = 24'h0;
  logic [7:0]  ack_last = 8'h00;
  logic        int_set = 1'b0;
  logic [7:0]  int_set_val = 8'h00;
  logic        force_low = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [7:0]  log_byte[512];
  logic        log_start[512];
  int          log_cyc[512];
  int          log_n = 0, cyc = 0, ack_cnt = 0, rsp_cnt = 0, irq_cnt = 0, dbl_cnt = 0;

  assign bus_din  = s_dout;
  assign int_in_n = force_low ? 1'b0 : ~|s_int;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_strobe <= bus_strobe;
    if (bus_strobe && prev_strobe) dbl_cnt <= dbl_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (irq_valid) irq_cnt <= irq_cnt + 1;
    if (int_set) s_int <= int_set_val;
    if (bus_strobe) begin
      log_byte[log_n % 512]  <= bus_dout;
      log_start[log_n % 512] <= bus_start;
      log_cyc[log_n % 512]   <= cyc;
      log_n <= log_n + 1;
      if (bus_start) begin
        s_cmd <= bus_dout;
        s_cnt <= 3'd0;
      end else begin
        s_cnt <= s_cnt + 3'd1;
        case (s_cmd)
          CMD_STATUS: s_dout <= (s_cnt == 3'd0) ? STATUS_MAGIC0 :
                                (s_cnt == 3'd1) ? STATUS_MAGIC1 : 8'h00;
          CMD_COLOR: begin
            s_dout <= 8'h00;
            case (s_cnt)
              3'd0:    s_color[23:16] <= rev8(bus_dout);
              3'd1:    s_color[15:8]  <= rev8(bus_dout);
              3'd2:    s_color[7:0]   <= rev8(bus_dout);
              default: ;
            endcase
          end
          CMD_CONFIG: s_dout <= bus_dout;
          CMD_IRQ: begin
            s_dout <= s_int;
            if (bus_dout != 8'h00) begin
              s_int    <= s_int & ~bus_dout;
              ack_last <= bus_dout;
              ack_cnt  <= ack_cnt + 1;
            end
          end
          default: s_dout <= 8'h00;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected strobe j of a transaction accepted so that its first strobe
  // lands in cycle t1: {start, byte, cycle}.
  function automatic logic [63:0] strobe_rec(input logic st, input logic [7:0] b, input int c);
    return {23'd0, st, b, c[31:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_user(input string name, input logic [7:0] c, input logic [2:0] l,
                          input logic [31:0] d, input logic [31:0] exp_rsp, input int pre);
    int n, lat_exp, base, t1, lat, rc0;
    bit got;
    logic [7:0] eb;
    n       = (l > 3'd4) ? 4 : int'(l);
    lat_exp = 2 + n * (GAP + 1) + GAP;
    @(negedge clk);
    base = log_n;
    rc0  = rsp_cnt;
    req_valid = 1'b1; req_cmd = c; req_len = l; req_data = d;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      check({name, " accept timeout"}, 64'(0), 64'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    t1 = cyc;
    req_valid = 1'b0;
    req_cmd = 8'($urandom); req_len = 3'($urandom); req_data = $urandom;
    lat = 0;
    for (int i = 1; i < 100; i++) begin
      if (rsp_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    check({name, " rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    repeat (3) @(posedge clk);
    #1;
    check({name, " rsp pulses"}, 64'(rsp_cnt - rc0), 64'(1));
    check({name, " rsp held"}, 64'(rsp_data), 64'(exp_rsp));
    check({name, " strobes"}, 64'(log_n - base), 64'(pre + n + 1));
    for (int j = 0; j <= n; j++) begin
      eb = (j == 0) ? c : d[8*(j-1) +: 8];
      check($sformatf("%s strobe%0d", name, j),
            strobe_rec(log_start[(base+pre+j) % 512], log_byte[(base+pre+j) % 512],
                       log_cyc[(base+pre+j) % 512]),
            strobe_rec(j == 0, eb, t1 + j * (GAP + 1)));
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [2:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  int base, rc0, ic0, ac0;
  bit seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"status2", CMD_STATUS, 3'd2, 32'h0000_0000, 32'h0000_425C};
    vecs[1] = '{"config4", CMD_CONFIG, 3'd4, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[2] = '{"len0",    CMD_CONFIG, 3'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[3] = '{"status4", CMD_STATUS, 3'd4, 32'h1122_3344, 32'h0000_425C};
    vecs[4] = '{"clamp7",  CMD_STATUS, 3'd7, 32'h0000_0000, 32'h0000_425C};
    vecs[5] = '{"config3", CMD_CONFIG, 3'd3, 32'hFFC3_B2A1, 32'h00C3_B2A1};
    vecs[6] = '{"color3",  CMD_COLOR,  3'd3, 32'h0080_4020, 32'h0000_0000};

    reset = 1'b1; req_valid = 1'b0; req_cmd = 8'h00; req_len = 3'd0; req_data = 32'h0;
    auto_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in reset outputs",
          64'({bus_strobe, bus_start, rsp_valid, irq_valid, busy, req_ready, bus_dout, rsp_data, irq_status}),
          64'({6'b000001, 8'h00, 32'h0, 8'h00}));
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post reset outputs",
          64'({bus_strobe, bus_start, rsp_valid, irq_valid, busy, req_ready, bus_dout, rsp_data, irq_status}),
          64'({6'b000001, 8'h00, 32'h0, 8'h00}));
    check("post reset state", 64'(fsm_state), 64'(ST_IDLE));

    // Table-driven user transactions.
    for (int v = 0; v < 7; v++)
      run_user(vecs[v].name, vecs[v].cmd, vecs[v].len, vecs[v].data, vecs[v].exp, 0);
    check("color register", 64'(s_color), 64'(24'h04_02_01));

    // Automatic interrupt service: read status 0x05, then acknowledge it.
    @(negedge clk);
    base = log_n; rc0 = rsp_cnt; ic0 = irq_cnt; ac0 = ack_cnt;
    auto_irq = 1'b1; int_set_val = 8'h05; int_set = 1'b1;
    @(negedge clk); int_set = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (irq_valid) begin seen = 1; break; end
    end
    check("irq seen", 64'(seen), 64'(1));
    check("irq status 05", 64'(irq_status), 64'(8'h05));
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; end
    check("irq back to idle", 64'(fsm_state), 64'(ST_IDLE));
    check("irq ack value", 64'(ack_last), 64'(8'h05));
    check("irq ack count", 64'(ack_cnt - ac0), 64'(1));
    check("irq slave cleared", 64'(s_int), 64'(8'h00));
    check("irq pulses", 64'(irq_cnt - ic0), 64'(1));
    check("irq no rsp", 64'(rsp_cnt - rc0), 64'(0));
    check("irq bus bytes",
          64'({log_start[base%512], log_byte[base%512], log_start[(base+1)%512], log_byte[(base+1)%512],
               log_start[(base+2)%512], log_byte[(base+2)%512], log_start[(base+3)%512], log_byte[(base+3)%512]}),
          64'({1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h05}));

    // Same-cycle tie: interrupt read first, user request completes after.
    @(negedge clk);
    base = log_n; ic0 = irq_cnt;
    int_set_val = 8'h03; int_set = 1'b1;
    @(posedge clk); #1; int_set = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_CONFIG; req_len = 3'd2; req_data = 32'h0000_BEEF;
    check("tie req_ready low", 64'({req_ready, fsm_state}), 64'({1'b0, ST_IDLE}));
    run_user("tie user", CMD_CONFIG, 3'd2, 32'h0000_BEEF, 32'h0000_BEEF, 4);
    check("tie irq status", 64'(irq_status), 64'(8'h03));
    check("tie irq pulses", 64'(irq_cnt - ic0), 64'(1));
    check("tie irq bytes",
          64'({log_start[base%512], log_byte[base%512], log_start[(base+1)%512], log_byte[(base+1)%512],
               log_start[(base+2)%512], log_byte[(base+2)%512], log_start[(base+3)%512], log_byte[(base+3)%512]}),
          64'({1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h03}));

    // Reset during the WAIT after the second payload strobe.
    auto_irq = 1'b0;
    @(negedge clk);
    base = log_n; rc0 = rsp_cnt;
    req_valid = 1'b1; req_cmd = CMD_STATUS; req_len = 3'd2; req_data = 32'h0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort in wait", 64'({fsm_state, 32'(log_n - base)}), 64'({ST_WAIT, 32'd3}));
    #1; reset = 1'b1;
    #1;
    check("async reset outputs",
          64'({bus_strobe, bus_start, rsp_valid, irq_valid, busy, req_ready, bus_dout, rsp_data, irq_status}),
          64'({6'b000001, 8'h00, 32'h0, 8'h00}));
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort no rsp", 64'(rsp_cnt - rc0), 64'(0));
    check("abort no strobes", 64'(log_n - base), 64'(3));
    run_user("after reset", CMD_STATUS, 3'd2, 32'h0, 32'h0000_425C, 0);

    // Forced interrupt with zero status: one read, no acknowledge.
    @(negedge clk);
    base = log_n; ac0 = ack_cnt;
    auto_irq = 1'b1; force_low = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (irq_valid) begin seen = 1; break; end
    end
    force_low = 1'b0;
    check("zero irq seen", 64'(seen), 64'(1));
    check("zero irq status", 64'(irq_status), 64'(8'h00));
    repeat (10) @(posedge clk);
    #1;
    check("zero irq strobes", 64'(log_n - base), 64'(2));
    check("zero irq no ack", 64'(ack_cnt - ac0), 64'(0));
    check("zero irq idle", 64'(fsm_state), 64'(ST_IDLE));
    check("no back-to-back strobes", 64'(dbl_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
